// File: rtl/xbar_grant_ctrl_pkg.sv
// xbar_grant_ctrl_pkg: shared FSM state type and queue-count helper
package xbar_grant_ctrl_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int calc_num(input int id_width);
    return 1 << id_width;
  endfunction
endpackage

// File: rtl/xbar_max_select.sv
// xbar_max_select: combinational argmax tree over (len, id) pairs, lower id wins ties
module xbar_max_select import xbar_grant_ctrl_pkg::*; #(
  parameter int LEN_WIDTH = 10,
  parameter int ID_WIDTH  = 5,
  localparam int NUM      = calc_num(ID_WIDTH)
) (
  input  logic [NUM*LEN_WIDTH-1:0] lens,
  output logic [LEN_WIDTH-1:0]     max_len,
  output logic [ID_WIDTH-1:0]      max_id
);
  // heap layout: leaves at NUM+k, node n merges 2n (lower ids) and 2n+1
  logic [LEN_WIDTH-1:0] node_len [1:2*NUM-1];
  logic [ID_WIDTH-1:0]  node_id  [1:2*NUM-1];
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      node_len[NUM+k] = lens[k*LEN_WIDTH +: LEN_WIDTH];
      node_id[NUM+k]  = ID_WIDTH'(k);
    end
    for (int n = NUM - 1; n >= 1; n--) begin
      node_len[n] = node_len[2*n+1] > node_len[2*n] ? node_len[2*n+1] : node_len[2*n];
      node_id[n]  = node_len[2*n+1] > node_len[2*n] ? node_id[2*n+1]  : node_id[2*n];
    end
  end
  assign max_len = node_len[1];
  assign max_id  = node_id[1];
endmodule

// File: rtl/xbar_grant_ctrl.sv
// xbar_grant_ctrl: grants the longest queue to the output and streams a bounded burst
module xbar_grant_ctrl import xbar_grant_ctrl_pkg::*; #(
  parameter int LEN_WIDTH  = 10,
  parameter int ID_WIDTH   = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int NUM       = calc_num(ID_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM*LEN_WIDTH-1:0]  q_len,
  input  logic [NUM*DATA_WIDTH-1:0] in_data,
  input  logic [NUM-1:0]            in_valid,
  output logic [NUM-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_WIDTH-1:0]       out_id,
  output logic                      out_last,
  output logic                      busy
);
  localparam logic [LEN_WIDTH-1:0] MAX_B = LEN_WIDTH'(MAX_BURST);
  localparam logic [LEN_WIDTH-1:0] ONE   = LEN_WIDTH'(1);
  state_t               state, state_nxt;
  logic [ID_WIDTH-1:0]  sel_id;
  logic [LEN_WIDTH-1:0] beat_cnt, max_len, burst_len;
  logic [ID_WIDTH-1:0]  max_id;
  logic                 fire, grant;
  xbar_max_select #(.LEN_WIDTH(LEN_WIDTH), .ID_WIDTH(ID_WIDTH)) u_max (
    .lens    (q_len),
    .max_len (max_len),
    .max_id  (max_id)
  );
  assign burst_len = max_len > MAX_B ? MAX_B : max_len;
  assign grant     = state == IDLE && max_len != '0;
  assign busy      = state == BURST;
  assign out_id    = sel_id;
  assign out_valid = busy && in_valid[sel_id];
  assign out_data  = busy ? in_data[sel_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign in_ready  = busy && out_ready ? NUM'(1) << sel_id : '0;
  assign out_last  = out_valid && beat_cnt == ONE;
  assign fire      = out_valid && out_ready;
  always_comb begin
    state_nxt = state == IDLE ? (grant ? BURST : IDLE) : (fire && beat_cnt == ONE ? IDLE : BURST);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_id   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        sel_id   <= max_id;
        beat_cnt <= burst_len;
      end else if (fire) begin
        beat_cnt <= beat_cnt - ONE;
      end
    end
  end
endmodule
